// File: rtl/cpu_control_sequencer_if.sv
// Instruction fetch bus between the control sequencer (master) and
// instruction memory (slave). The sequencer drives address and request;
// memory answers with ack and the instruction word.
interface cpu_control_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] instr_addr;
  logic                mem_req;
  logic                mem_ack;
  logic [7:0]          instr_data;

  modport master (
    output instr_addr,
    output mem_req,
    input  mem_ack,
    input  instr_data
  );

  modport slave (
    input  instr_addr,
    input  mem_req,
    output mem_ack,
    output instr_data
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control unit for the 8-bit CPU: fetches one instruction at a
// time over a req/ack handshake, holds the PC and sequences register-file
// selects, Type4 NOT / branch enables and the ALU enable.
// Optional build macro CTRL_SINGLE_STEP_EN adds i_step and a STEP_WAIT state
// that gates every entry into FETCH.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for i_start, all outputs low
// STEP_WAIT   | (CTRL_SINGLE_STEP_EN only) waiting for i_step before FETCH
// FETCH       | mem_req high until mem_ack; latch IR, PC+1
// DECODE      | drive read selects; HALT opcode -> HALT
// EXECUTE     | one enable per opcode; JMP loads PC and refetches
// WRITEBACK   | write strobe to rd, enable held so the result stays valid
// HALT        | o_halted high; only reset leaves
module cpu_control_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                   i_step,
`endif
  input  logic [7:0]             i_branch_target,
  cpu_control_sequencer_if.master mem_if,
  output logic [1:0]             o_r_signal1,
  output logic [1:0]             o_r_signal2,
  output logic [1:0]             o_write_register_selection,
  output logic                   o_write_enable,
  output logic                   o_not_selection,
  output logic                   o_unconditional_br_selection,
  output logic                   o_alu_selection,
  output logic                   o_halted,
  output logic                   o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
`ifdef CTRL_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t L_FETCH_ENTRY = S_STEP_WAIT;
`else
  localparam state_t L_FETCH_ENTRY = S_FETCH;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [7:0]          r_ir;
  logic [7:0]          w_ir_next;
  logic [PC_WIDTH-1:0] w_branch_pc;
  logic [1:0]          w_opcode;

  logic       w_mem_req;
  logic [1:0] w_rsel1;
  logic [1:0] w_rsel2;
  logic [1:0] w_wsel;
  logic       w_we;
  logic       w_not_en;
  logic       w_br_en;
  logic       w_alu_en;
  logic       w_halted;

  assign w_opcode = r_ir[7:6];

  // Branch target comes from an 8-bit register; zero-extend or truncate to the PC.
  generate
    if (PC_WIDTH >= 8) begin : g_bt_wide
      assign w_branch_pc = PC_WIDTH'(i_branch_target);
    end else begin : g_bt_narrow
      assign w_branch_pc = i_branch_target[PC_WIDTH-1:0];
    end
  endgenerate

  // State, PC and IR registers; reset wins over everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Next-state, PC/IR update and Moore outputs decoded from state and IR.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_mem_req    = 1'b0;
    w_rsel1      = 2'b00;
    w_rsel2      = 2'b00;
    w_wsel       = 2'b00;
    w_we         = 1'b0;
    w_not_en     = 1'b0;
    w_br_en      = 1'b0;
    w_alu_en     = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = L_FETCH_ENTRY;
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (i_step) w_state_next = S_FETCH;
      end
`endif
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_if.mem_ack) begin
          w_ir_next    = mem_if.instr_data;
          w_pc_next    = r_pc + PC_WIDTH'(1);
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_rsel1      = r_ir[3:2];
        w_rsel2      = r_ir[1:0];
        w_state_next = (w_opcode == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        w_rsel1  = r_ir[3:2];
        w_rsel2  = r_ir[1:0];
        w_alu_en = (w_opcode == OP_ADD);
        w_not_en = (w_opcode == OP_NOT);
        w_br_en  = (w_opcode == OP_JMP);
        if (w_opcode == OP_JMP) begin
          w_pc_next    = w_branch_pc;
          w_state_next = L_FETCH_ENTRY;
        end else begin
          w_state_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        w_rsel1      = r_ir[3:2];
        w_rsel2      = r_ir[1:0];
        w_wsel       = r_ir[5:4];
        w_we         = 1'b1;
        w_alu_en     = (w_opcode == OP_ADD);
        w_not_en     = (w_opcode == OP_NOT);
        w_state_next = L_FETCH_ENTRY;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign mem_if.instr_addr            = r_pc;
  assign mem_if.mem_req               = w_mem_req;
  assign o_r_signal1                  = w_rsel1;
  assign o_r_signal2                  = w_rsel2;
  assign o_write_register_selection   = w_wsel;
  assign o_write_enable               = w_we;
  assign o_not_selection              = w_not_en;
  assign o_unconditional_br_selection = w_br_en;
  assign o_alu_selection              = w_alu_en;
  assign o_halted                     = w_halted;
  assign o_busy                       = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer. Every fetched instruction
// pushes its expected decode record; the per-cycle checks pop it and walk
// DECODE / EXECUTE / WRITEBACK against it. Inputs change and outputs are
// sampled on the falling edge.
module tb_cpu_control_sequencer;
  localparam int PCW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic [7:0] bt;
  logic [1:0] rs1, rs2, wsel;
  logic       we, not_sel, br_sel, alu_sel, halted, busy;

  cpu_control_sequencer_if #(.PC_WIDTH(PCW)) mem_if();

  cpu_control_sequencer #(.PC_WIDTH(PCW), .RESET_PC(8'h00)) dut (
    .i_clock                      (clk),
    .i_reset                      (rst),
    .i_start                      (start),
`ifdef CTRL_SINGLE_STEP_EN
    .i_step                       (step),
`endif
    .i_branch_target              (bt),
    .mem_if                       (mem_if),
    .o_r_signal1                  (rs1),
    .o_r_signal2                  (rs2),
    .o_write_register_selection   (wsel),
    .o_write_enable               (we),
    .o_not_selection              (not_sel),
    .o_unconditional_br_selection (br_sel),
    .o_alu_selection              (alu_sel),
    .o_halted                     (halted),
    .o_busy                       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] bt;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_pc;

  // {req, rs1, rs2, wsel, we, alu, not, br, halted, busy}
  logic [12:0] obs;
  assign obs = {mem_if.mem_req, rs1, rs2, wsel, we, alu_sel, not_sel, br_sel, halted, busy};

  function automatic logic [12:0] ev(input logic req, input logic [1:0] r1, input logic [1:0] r2,
                                     input logic [1:0] ws, input logic w, input logic a,
                                     input logic n, input logic b, input logic h, input logic bz);
    return {req, r1, r2, ws, w, a, n, b, h, bz};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic step_gate();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (mem_if.mem_req !== 1'b0)
        begin errors++; $display("FAIL step_wait_req cycle=%0d got=%b want=0", i, mem_if.mem_req); end
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1)
      begin errors++; $display("FAIL step_release_req got=%b want=1", mem_if.mem_req); end
  endtask
`endif

  // Pops one expected record and checks the post-fetch cycles.
  task automatic check_instr(input bit rst_in_wb);
    exp_t        e;
    logic [12:0] x;
    e = exp_q.pop_front();
    x = ev(1'b0, e.rs1, e.rs2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== x) begin errors++; $display("FAIL decode op=%0d got=%b want=%b", e.op, obs, x); end
    // stray ack outside FETCH must not disturb IR
    mem_if.mem_ack    = 1'b1;
    mem_if.instr_data = 8'hFF;
    @(negedge clk);
    mem_if.mem_ack    = 1'b0;
    if (e.op == 2'b11) begin
      x = ev(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== x) begin errors++; $display("FAIL halt_state got=%b want=%b", obs, x); end
    end else begin
      x = ev(1'b0, e.rs1, e.rs2, 2'b00, 1'b0, e.op == 2'b00, e.op == 2'b01, e.op == 2'b10, 1'b0, 1'b1);
      checks++;
      if (obs !== x) begin errors++; $display("FAIL execute op=%0d got=%b want=%b", e.op, obs, x); end
      if (e.op == 2'b10) begin
        model_pc = e.bt;
        @(negedge clk);
      end else begin
        @(negedge clk);
        x = ev(1'b0, e.rs1, e.rs2, e.rd, 1'b1, e.op == 2'b00, e.op == 2'b01, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== x) begin errors++; $display("FAIL writeback op=%0d got=%b want=%b", e.op, obs, x); end
        if (rst_in_wb) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          model_pc = 8'h00;
          checks++;
          if (obs !== 13'd0 || mem_if.instr_addr !== 8'h00)
            begin errors++; $display("FAIL reset_in_wb got=%b addr=%h want=0 addr=00", obs, mem_if.instr_addr); end
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic do_fetch(input logic [7:0] data, input int delay, input logic [7:0] btv, input bit rst_wb);
    int n;
`ifdef CTRL_SINGLE_STEP_EN
    step_gate();
`endif
    n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL wait_req timeout got=%b want=1", mem_if.mem_req); end
    checks++;
    if (mem_if.instr_addr !== model_pc)
      begin errors++; $display("FAIL fetch_addr got=%h want=%h", mem_if.instr_addr, model_pc); end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (mem_if.mem_req !== 1'b1 || mem_if.instr_addr !== model_pc)
        begin errors++; $display("FAIL ack_wait cycle=%0d req=%b addr=%h want req=1 addr=%h", i, mem_if.mem_req, mem_if.instr_addr, model_pc); end
    end
    mem_if.mem_ack    = 1'b1;
    mem_if.instr_data = data;
    bt                = btv;
    exp_q.push_back({data[7:6], data[5:4], data[3:2], data[1:0], btv});
    model_pc = model_pc + 8'd1;
    @(negedge clk);
    mem_if.mem_ack    = 1'b0;
    mem_if.instr_data = 8'h00;
    check_instr(rst_wb);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 13'd0 || mem_if.instr_addr !== 8'h00)
      begin errors++; $display("FAIL reset_hold got=%b addr=%h want=0 addr=00", obs, mem_if.instr_addr); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL idle_after_reset got=%b want=0", obs); end
    model_pc = 8'h00;
  endtask

  task automatic test_halt();
    logic [12:0] x;
    do_fetch(8'hC0, 0, 8'h00, 1'b0);
    pulse_start();
    x = ev(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== x) begin errors++; $display("FAIL halt_ignores_start cycle=%0d got=%b want=%b", i, obs, x); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bt = 8'h00;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    mem_if.mem_ack = 1'b0; mem_if.instr_data = 8'h00;
    model_pc = 8'h00;
    @(negedge clk);
    test_reset();
    pulse_start();
    do_fetch(8'h1B, 0, 8'h00, 1'b0);   // ADD rd=1 rs1=2 rs2=3 at 00
    do_fetch(8'h64, 0, 8'h00, 1'b0);   // NOT rd=2 rs1=1 at 01
    do_fetch(8'h88, 0, 8'h40, 1'b0);   // JMP via r2 -> 40
    do_fetch(8'h8C, 2, 8'hFF, 1'b0);   // JMP via r3 -> FF, short ack delay
    do_fetch(8'h1B, 5, 8'h00, 1'b0);   // ADD at FF, PC wraps to 00
    test_halt();                       // HALT at 00
    test_reset();
    pulse_start();
    do_fetch(8'h64, 0, 8'h00, 1'b1);   // reset lands in WRITEBACK
    pulse_start();
    do_fetch(8'h1B, 0, 8'h00, 1'b0);   // back-to-back after reset
    do_fetch(8'h39, 1, 8'h00, 1'b0);   // ADD rd=3 rs1=2 rs2=1
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
